// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: host opcodes, controller
// states and halt causes.
package pipe_ctrl_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_RUN      = 3'd1;
  localparam logic [2:0] OP_RUN_N    = 3'd2;
  localparam logic [2:0] OP_STEP_N   = 3'd3;
  localparam logic [2:0] OP_STOP     = 3'd4;
  localparam logic [2:0] OP_PC_RESET = 3'd5;
  localparam logic [2:0] OP_CLR_CNT  = 3'd6;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_RUN_N   = 3'd2;
  localparam logic [2:0] ST_STEP_HI = 3'd3;
  localparam logic [2:0] ST_STEP_LO = 3'd4;
  localparam logic [2:0] ST_PCRST   = 3'd5;

  localparam logic [1:0] HALT_NONE = 2'd0;
  localparam logic [1:0] HALT_STOP = 2'd1;
  localparam logic [1:0] HALT_BP   = 2'd2;
  localparam logic [1:0] HALT_DONE = 2'd3;

  function automatic logic isRunState(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_RUN_N);
  endfunction

endpackage

// File: rtl/pipe_cycle_counter.sv
// 32-bit wrapping count of cycles in which the pipeline advanced.
module pipe_cycle_counter
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= 32'd0;
    end else if (inc) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Host-facing run/step controller for the pipeline: free run, bounded run,
// single stepping, PC reset and breakpoint halting.
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        cmd_ready,
  input  logic [8:0]  pc_dbg,
  input  logic        bp_en,
  input  logic [8:0]  bp_pc,
  output logic        run,
  output logic        step,
  output logic        pc_reset_pulse,
  output logic        host_mem_grant,
  output logic        busy,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_count
);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  halt_q, halt_d;
  logic        first_q, first_d;

  logic        accept, stopAcc, bpHit, clrCnt;
  logic [31:0] cntDec;

  assign cmd_ready = (state_q == ST_IDLE) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign stopAcc   = accept && (cmd_op == OP_STOP);
  assign clrCnt    = accept && (state_q == ST_IDLE) && (cmd_op == OP_CLR_CNT);
  assign cntDec    = cnt_q - 32'd1;

  // The first cycle of a run is exempt so a run can resume sitting on bp_pc.
  assign bpHit = bp_en && (pc_dbg == bp_pc) && isRunState(state_q) && !first_q;

  assign run            = isRunState(state_q) && !bpHit;
  assign step           = (state_q == ST_STEP_HI);
  assign pc_reset_pulse = (state_q == ST_PCRST);
  assign host_mem_grant = (state_q == ST_IDLE);
  assign busy           = !host_mem_grant;
  assign halt_cause     = halt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    halt_d  = halt_q;
    first_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              halt_d  = HALT_NONE;
              first_d = 1'b1;
            end
            OP_RUN_N: begin
              if (cmd_arg != 32'd0) begin
                state_d = ST_RUN_N;
                cnt_d   = cmd_arg;
                halt_d  = HALT_NONE;
                first_d = 1'b1;
              end else begin
                halt_d = HALT_DONE;
              end
            end
            OP_STEP_N: begin
              if (cmd_arg != 32'd0) begin
                state_d = ST_STEP_HI;
                cnt_d   = cmd_arg;
                halt_d  = HALT_NONE;
              end else begin
                halt_d = HALT_DONE;
              end
            end
            OP_PC_RESET: state_d = ST_PCRST;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (bpHit) begin
          state_d = ST_IDLE;
          halt_d  = HALT_BP;
        end else if (stopAcc) begin
          state_d = ST_IDLE;
          halt_d  = HALT_STOP;
        end
      end
      // Halt priority: breakpoint, then count expiry, then host STOP.
      ST_RUN_N: begin
        if (bpHit) begin
          state_d = ST_IDLE;
          halt_d  = HALT_BP;
        end else if (cnt_q == 32'd1) begin
          state_d = ST_IDLE;
          halt_d  = HALT_DONE;
          cnt_d   = 32'd0;
        end else if (stopAcc) begin
          state_d = ST_IDLE;
          halt_d  = HALT_STOP;
        end else begin
          cnt_d = cntDec;
        end
      end
      ST_STEP_HI: begin
        if (stopAcc) begin
          state_d = ST_IDLE;
          halt_d  = HALT_STOP;
        end else begin
          state_d = ST_STEP_LO;
        end
      end
      ST_STEP_LO: begin
        cnt_d = cntDec;
        if (cntDec == 32'd0) begin
          state_d = ST_IDLE;
          halt_d  = HALT_DONE;
        end else if (stopAcc) begin
          state_d = ST_IDLE;
          halt_d  = HALT_STOP;
        end else begin
          state_d = ST_STEP_HI;
        end
      end
      ST_PCRST: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 32'd0;
      halt_q  <= HALT_NONE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      first_q <= first_d;
    end
  end

  pipe_cycle_counter u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (run || step),
    .clr   (clrCnt),
    .count (cycle_count)
  );

endmodule

// File: doc/pipe_run_ctrl.md
PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 SHALL use these ports (name direction width meaning); clk and reset are listed first:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command strobe
- cmd_op  in  3  opcode: 0 NOP, 1 RUN, 2 RUN_N, 3 STEP_N, 4 STOP, 5 PC_RESET, 6 CLR_CNT
- cmd_arg  in  32  cycle or step count for RUN_N and STEP_N
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- pc_dbg  in  9  current pipeline PC
- bp_en  in  1  breakpoint enable
- bp_pc  in  9  breakpoint PC
- run  out  1  pipeline run level
- step  out  1  pipeline single-cycle step pulse
- pc_reset_pulse  out  1  pipeline PC reset pulse
- host_mem_grant  out  1  host may access imem/dmem program ports
- busy  out  1  state not IDLE
- halt_cause  out  2  0 NONE, 1 STOP, 2 BP, 3 DONE
- cycle_count  out  32  count of cycles in which pipeline advanced
REQ-002 SHALL clock all state on posedge clk; reset is synchronous and active-high.

Function
REQ-003 SHALL implement the states IDLE, RUN, RUN_N, STEP_HI, STEP_LO and PCRST.
REQ-004 cmd_ready SHALL be 1 in IDLE for all ops; in any other state it SHALL be 1 only when cmd_op=STOP.
REQ-005 The accept cycle T (cmd_valid&cmd_ready) SHALL cause these transitions at T+1:
- RUN -> RUN
- RUN_N with arg>0 -> RUN_N, remaining counter=arg
- RUN_N with arg=0 -> IDLE, halt_cause=DONE, no run cycles
- STEP_N with arg>0 -> STEP_HI, remaining counter=arg
- STEP_N with arg=0 -> IDLE, halt_cause=DONE
- PC_RESET -> PCRST
- CLR_CNT -> cycle_count=0, state stays IDLE
- NOP -> no effect
REQ-006 Accepting RUN, RUN_N or STEP_N SHALL set halt_cause=NONE at T+1.
REQ-007 bp_hit SHALL = bp_en & (pc_dbg==bp_pc) & state in {RUN,RUN_N} & not first cycle of that run; the first-cycle exemption lets a run resume from a breakpoint.
REQ-008 run SHALL = state in {RUN,RUN_N} & ~bp_hit (combinational mask), so PC never advances past bp_pc.
REQ-009 On bp_hit the next state SHALL be IDLE and halt_cause SHALL be BP.
REQ-010 RUN_N SHALL assert run for exactly arg cycles (T+1..T+arg) unless halted earlier, then go to IDLE with halt_cause=DONE.
REQ-011 STEP_HI SHALL drive step=1 for one cycle; STEP_LO SHALL drive step=0 and decrement the counter.
REQ-012 From STEP_LO, counter 0 SHALL go to IDLE with halt_cause=DONE; otherwise it SHALL go to STEP_HI. This gives arg pulses at a 2-cycle period.
REQ-013 PCRST SHALL drive pc_reset_pulse=1 for exactly one cycle, then return to IDLE; halt_cause and cycle_count are unchanged.
REQ-014 Accepted STOP in RUN, RUN_N or STEP_* SHALL give IDLE next cycle with halt_cause=STOP; run and step SHALL be 0 from T+1.
REQ-015 Accepted STOP in IDLE SHALL have no effect.
REQ-016 Simultaneous halt events SHALL resolve with priority bp_hit > count expiry (DONE) > STOP.
REQ-017 cycle_count SHALL increment by 1 on each cycle where run|step=1, wrapping from 0xFFFFFFFF to 0.
REQ-018 host_mem_grant SHALL = (state==IDLE); busy SHALL = ~host_mem_grant.
REQ-019 The remaining counter SHALL be 32-bit unsigned, with no saturation needed.

Reset
REQ-020 Reset SHALL set state=IDLE, run=0, step=0, pc_reset_pulse=0, halt_cause=NONE, cycle_count=0, counter=0 and the first-cycle flag clear.
REQ-021 Reset asserted mid-operation SHALL abort immediately, with run/step 0 on the next edge; any command offered during reset SHALL be ignored.

Structure
REQ-022 Opcode, state and halt_cause encodings SHALL live in shared package pipe_ctrl_pkg.
REQ-023 The 32-bit wrapping cycle_count SHALL be sub-module pipe_cycle_counter (inc, clr inputs); all other logic SHALL be inline.
REQ-024 Outputs run and step SHALL feed the pipeline run/step inputs directly, with no edge detection needed downstream.

Verification
REQ-025 RUN_N, arg=5, bp_en=0 -> run high exactly 5 cycles, then halt_cause=3, cycle_count=5, host_mem_grant=1.
REQ-026 RUN, bp_en=1, bp_pc=0x010, PC incrementing from 0 -> run low in the cycle pc_dbg=0x010, halt_cause=2. A second RUN from pc 0x010 -> run stays high past 0x010.
REQ-027 STEP_N, arg=3 -> step pattern 1,0,1,0,1,0, then IDLE, halt_cause=3, cycle_count +3.
REQ-028 RUN, STOP after 4 cycles -> run=0 from the cycle after accept, halt_cause=1, and cmd_ready=0 for RUN ops while busy.
REQ-029 RUN_N arg=10, reset at cycle 4 -> run=0 next edge, all outputs at reset values. Separately: PC_RESET -> single pc_reset_pulse; RUN_N arg=0 -> DONE with no run cycle.
REQ-030 RUN_N arg=3 with bp_hit on its 3rd cycle -> halt_cause=2, not 3.
